i2s_transmitter: RTL and testbench
==================================

// Module: i2s_transmitter
// PURPOSE
//   I2S master transmitter feeding the codec DAC. Accepts parallel stereo samples from effect
//   blocks (echo, etc.) via valid/ready and serializes them MSB-first onto sdata.
//   Generates lrclk from bclk. Mirror of the receive path that produces left_in/right_in.
// PARAMETERS
//   DATALEN  16  bits per sample, two's complement
//   SLOTLEN  32  bclk cycles per channel slot; power of 2, >= DATALEN+1; frame = 2*SLOTLEN
// PORTS
//   bclk        in   1        serial bit clock; all logic on posedge
//   rst_n       in   1        asynchronous, active-low reset
//   left_in     in   DATALEN  left sample
//   right_in    in   DATALEN  right sample
//   in_valid    in   1        left_in/right_in valid
//   in_ready    out  1        holding register empty; transfer when in_valid & in_ready
//   lrclk       out  1        word select: 0 = left slot, 1 = right slot
//   sdata       out  1        serial data to DAC
//   frame_start out  1        1-cycle pulse on the cycle slot counter is 0
//   underrun    out  1        1-cycle pulse when a frame loads with no sample held
// BEHAVIOUR
//   - One clock (bclk), asynchronous active-low reset rst_n. All outputs registered.
//   - Top level drives codec SCK pin with ~bclk, so the codec samples mid-bit.
//   - Reset: cnt=0, lrclk=0, sdata=0, frame_start=0, underrun=0, hold empty (in_ready=1),
//     shift regs=0. rst_n mid-frame aborts the frame; the first frame after release is silent.
//   - cnt: 0..2*SLOTLEN-1, +1 per bclk, wraps to 0. lrclk = cnt bit log2(SLOTLEN).
//   - Slot position p = cnt mod SLOTLEN. p=0: sdata=0 (I2S 1-bit delay).
//     p=1..DATALEN: sdata = sample bit DATALEN-p (MSB first). p>DATALEN: sdata=0.
//   - Hold register: on in_valid & in_ready, capture {left_in,right_in} and set full.
//     in_ready = !full.
//   - Frame load on the cycle cnt wraps to 0. If full: shift regs <= hold, full <= 0.
//     If empty: underrun pulse, and shift regs load per the macro below.
//   - Accept and load in the same cycle with hold empty: this frame underruns.
//     The accepted sample stays held for the next frame.
//   - Latency: sample held before a wrap -> its left MSB on sdata at cnt=1 of the next
//     frame; right MSB at cnt=SLOTLEN+1.
//   - No arithmetic on samples; bits pass unmodified, sign bit first.
// CONFIGURATION
//   I2S_TX_HOLD_LAST_EN defined: on underrun, the last transmitted sample pair is resent.
//   Undefined: on underrun, zeros are sent (mute). underrun pulses in both cases.
// STRUCTURE
//   Package i2s_pkg: DATALEN/SLOTLEN defaults, sample_t (logic [DATALEN-1:0]),
//   stereo_t {sample_t l, r}.
//   Sub-module i2s_slot_serializer: DATALEN shift reg + slot position -> sdata,
//   instantiated once and reloaded per slot.
//   Top: counter, lrclk, hold register, handshake, underrun/frame_start.
// TESTING
//   1. Reset release, in_valid=0: lrclk toggles every 32 bclk; sdata=0;
//      underrun pulses at every cnt=0; in_ready=1.
//   2. Send L=16'hA5C3, R=16'h8001 before the wrap: at cnt=1..16 sdata=1010010111000011;
//      at cnt=33..48 sdata=1000000000000001; sdata=0 elsewhere.
//   3. Hold full, in_valid held high: in_ready=0 until the load cycle; second sample goes
//      out in the next frame; no sample dropped or duplicated.
//   4. in_valid asserted on the exact wrap cycle with hold empty: underrun=1 that cycle;
//      the sample appears in the following frame.
//   5. After L=16'h7FFF, R=16'h0001, starve one frame: with I2S_TX_HOLD_LAST_EN,
//      7FFF/0001 resent; without it, 16 zero bits per slot.
//   6. Drop rst_n at cnt=20 mid-left slot: lrclk, sdata, cnt go 0 immediately (async);
//      hold cleared; clean frame after release.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared widths and sample types for the I2S transmit path
package i2s_pkg;

    localparam int DATALEN = 16;
    localparam int SLOTLEN = 32;
    localparam int POSW    = $clog2(SLOTLEN);
    localparam int CNTW    = POSW + 1;

    typedef logic [DATALEN-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/i2s_slot_serializer.sv
// rtl/i2s_slot_serializer.sv - one-slot MSB-first shift register with the I2S one-bit delay
module i2s_slot_serializer #(
    parameter int DATALEN = 16,
    parameter int POSW    = 5
) (
    input  logic               bclk,
    input  logic               rst_n,
    input  logic [POSW-1:0]    pos_i,
    input  logic [DATALEN-1:0] load_data_i,
    output logic               sdata_o
);

    localparam logic [POSW-1:0] LAST_POS = POSW'(DATALEN);

    logic [DATALEN-1:0] shift_q;
    logic [DATALEN-1:0] shift_d;
    logic               sdata_q;
    logic               sdata_d;

    // pos_i is the slot position about to be entered: position 0 reloads and idles the line,
    // positions 1..DATALEN emit the MSB and shift, the padding tail stays low
    always_comb begin
        shift_d = shift_q;
        sdata_d = 1'b0;
        if (pos_i == '0) begin
            shift_d = load_data_i;
        end else if (pos_i <= LAST_POS) begin
            sdata_d = shift_q[DATALEN-1];
            shift_d = {shift_q[DATALEN-2:0], 1'b0};
        end
    end

    // Shift register and registered serial output
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            sdata_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            sdata_q <= sdata_d;
        end
    end

    assign sdata_o = sdata_q;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter; I2S_TX_HOLD_LAST_EN repeats the last pair on underrun
module i2s_transmitter
    import i2s_pkg::*;
(
    input  logic    bclk,
    input  logic    rst_n,
    input  sample_t left_in,
    input  sample_t right_in,
    input  logic    in_valid,
    output logic    in_ready,
    output logic    lrclk,
    output logic    sdata,
    output logic    frame_start,
    output logic    underrun
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            lrclk_q;
    logic            lrclk_d;
    logic            frame_start_q;
    logic            frame_start_d;
    logic            underrun_q;
    logic            underrun_d;
    logic            full_q;
    logic            full_d;
    stereo_t         hold_q;
    stereo_t         hold_d;
    stereo_t         frame_q;
    stereo_t         frame_d;
    stereo_t         refill;
    logic            accept;
    logic            wrap;
    logic [POSW-1:0] pos_d;
    sample_t         slot_data;

    assign accept = in_valid & ~full_q;

`ifdef I2S_TX_HOLD_LAST_EN
    // Starved frame repeats whatever pair was last on the wire
    assign refill = frame_q;
`else
    // Starved frame is muted
    assign refill = '0;
`endif

    // Frame counter, hold register handshake and frame load; all flags are computed from the
    // next counter value so every output comes straight from a flop
    always_comb begin
        cnt_d         = cnt_q + CNT_ONE;
        wrap          = (cnt_d == '0);
        pos_d         = cnt_d[POSW-1:0];
        lrclk_d       = cnt_d[POSW];
        frame_start_d = wrap;
        underrun_d    = wrap & ~full_q;
        hold_d        = hold_q;
        full_d        = full_q;
        frame_d       = frame_q;
        if (accept) begin
            hold_d = '{l: left_in, r: right_in};
            full_d = 1'b1;
        end
        // A sample accepted on the wrap edge itself is too late for this frame and stays held
        if (wrap) begin
            if (full_q) begin
                frame_d = hold_q;
                full_d  = 1'b0;
            end else begin
                frame_d = refill;
            end
        end
        // Left slot takes the pair being loaded right now, right slot the pair already in frame_q
        slot_data = lrclk_d ? frame_q.r : frame_d.l;
    end

    // State registers
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            lrclk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            full_q        <= 1'b0;
            hold_q        <= '0;
            frame_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            lrclk_q       <= lrclk_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            full_q        <= full_d;
            hold_q        <= hold_d;
            frame_q       <= frame_d;
        end
    end

    i2s_slot_serializer #(
        .DATALEN (DATALEN),
        .POSW    (POSW)
    ) u_serializer (
        .bclk        (bclk),
        .rst_n       (rst_n),
        .pos_i       (pos_d),
        .load_data_i (slot_data),
        .sdata_o     (sdata)
    );

    assign in_ready    = ~full_q;
    assign lrclk       = lrclk_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - scoreboard bench for i2s_transmitter (frame-level expectations)
module tb_i2s_transmitter;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } exp_t;

    logic        bclk;
    logic        rst_n;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        in_valid;
    logic        in_ready;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        underrun;

    int          tests_run    = 0;
    int          tests_failed = 0;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          cur_valid = 1'b0;
    bit          fresh     = 1'b0;
    logic [15:0] last_l    = '0;
    logic [15:0] last_r    = '0;
    logic [5:0]  tb_cnt;
    int          pos;
    logic [15:0] word;
    logic        exp_bit;

    i2s_transmitter dut (
        .bclk        (bclk),
        .rst_n       (rst_n),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    always @(posedge bclk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 6'd1;
    end

    always @(negedge bclk) begin
        if (rst_n === 1'b1) begin
            if (tb_cnt == 6'd0) begin
                if (fresh) begin
                    tests_run++;
                    if (frame_start !== 1'b0 || underrun !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL first_frame_flags got fs=%b ur=%b exp fs=0 ur=0", frame_start, underrun);
                    end
                    cur       = '0;
                    cur_valid = 1'b1;
                    fresh     = 1'b0;
                end else begin
                    tests_run++;
                    if (frame_start !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL frame_start got=%b exp=1", frame_start);
                    end
                    if (exp_q.size() > 0) begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1'b1;
                        tests_run++;
                        if (underrun !== cur.und) begin
                            tests_failed++;
                            $display("FAIL underrun got=%b exp=%b", underrun, cur.und);
                        end
                    end else begin
                        cur_valid = 1'b0;
                    end
                end
            end else begin
                tests_run++;
                if (frame_start !== 1'b0 || underrun !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL pulse_width cnt=%0d got fs=%b ur=%b exp 0 0", tb_cnt, frame_start, underrun);
                end
            end
            tests_run++;
            if (lrclk !== tb_cnt[5]) begin
                tests_failed++;
                $display("FAIL lrclk cnt=%0d got=%b exp=%b", tb_cnt, lrclk, tb_cnt[5]);
            end
            if (cur_valid) begin
                pos     = int'(tb_cnt[4:0]);
                exp_bit = 1'b0;
                if (pos >= 1 && pos <= 16) begin
                    word    = tb_cnt[5] ? cur.r : cur.l;
                    exp_bit = word[16-pos];
                end
                tests_run++;
                if (sdata !== exp_bit) begin
                    tests_failed++;
                    $display("FAIL sdata cnt=%0d got=%b exp=%b frame=%h/%h", tb_cnt, sdata, exp_bit, cur.l, cur.r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back('{l: l, r: r, und: 1'b0});
        last_l = l;
        last_r = r;
    endtask

    task automatic push_underrun();
`ifdef I2S_TX_HOLD_LAST_EN
        exp_q.push_back('{l: last_l, r: last_r, und: 1'b1});
`else
        exp_q.push_back('{l: 16'h0000, r: 16'h0000, und: 1'b1});
`endif
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge bclk);
            if (int'(tb_cnt) == target) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL wait_cnt got=timeout exp=cnt%0d", target);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge bclk);
        end
        tests_run++;
        tests_failed++;
        $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        left_in  = l;
        right_in = r;
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) begin
                @(negedge bclk);
                in_valid = 1'b0;
                return;
            end
            @(negedge bclk);
        end
        in_valid = 1'b0;
        tests_run++;
        tests_failed++;
        $display("FAIL send_handshake got=timeout exp=accept");
    endtask

    task automatic release_reset();
        @(posedge bclk);
        #2;
        fresh     = 1'b1;
        cur_valid = 1'b0;
        last_l    = '0;
        last_r    = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        left_in  = '0;
        right_in = '0;
        repeat (4) @(negedge bclk);
        tests_run++;
        if (lrclk !== 1'b0 || sdata !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_lines got lr=%b sd=%b exp 0 0", lrclk, sdata);
        end
        tests_run++;
        if (frame_start !== 1'b0 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses got fs=%b ur=%b exp 0 0", frame_start, underrun);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        release_reset();
    endtask

    task automatic test_idle();
        push_underrun();
        push_underrun();
        for (int i = 0; i < 140; i++) begin
            @(negedge bclk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL idle_in_ready cyc=%0d got=%b exp=1", i, in_ready);
            end
        end
        drain();
    endtask

    task automatic test_pattern();
        wait_cnt(5);
        send(16'hA5C3, 16'h8001);
        push_sample(16'hA5C3, 16'h8001);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL pattern_in_ready got=%b exp=0", in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        wait_cnt(3);
        send(16'h1357, 16'hFEDC);
        push_sample(16'h1357, 16'hFEDC);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_full got=%b exp=0", in_ready);
        end
        in_valid = 1'b1;
        left_in  = 16'h8000;
        right_in = 16'h00FF;
        wait_cnt(63);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stall got=%b exp=0", in_ready);
        end
        @(negedge bclk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_freed_at_load got=%b exp=1", in_ready);
        end
        @(negedge bclk);
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_accept got=%b exp=0", in_ready);
        end
        push_sample(16'h8000, 16'h00FF);
        push_underrun();
        drain();
    endtask

    task automatic test_wrap_accept();
        push_underrun();
        push_sample(16'h4BD2, 16'hC3A5);
        wait_cnt(63);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pre_ready got=%b exp=1", in_ready);
        end
        in_valid = 1'b1;
        left_in  = 16'h4BD2;
        right_in = 16'hC3A5;
        @(negedge bclk);
        in_valid = 1'b0;
        tests_run++;
        if (underrun !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_accept got ur=%b rdy=%b exp ur=1 rdy=0", underrun, in_ready);
        end
        drain();
    endtask

    task automatic test_underrun_fill();
        wait_cnt(4);
        send(16'h7FFF, 16'h0001);
        push_sample(16'h7FFF, 16'h0001);
        push_underrun();
        drain();
    endtask

    task automatic test_reset_midframe();
        wait_cnt(0);
        wait_cnt(2);
        send(16'h1234, 16'h5678);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_pre_full got=%b exp=0", in_ready);
        end
        wait_cnt(20);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (lrclk !== 1'b0 || sdata !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_lines got lr=%b sd=%b exp 0 0", lrclk, sdata);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_hold_cleared got=%b exp=1", in_ready);
        end
        tests_run++;
        if (frame_start !== 1'b0 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_pulses got fs=%b ur=%b exp 0 0", frame_start, underrun);
        end
        repeat (2) @(negedge bclk);
        release_reset();
        wait_cnt(5);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_post_ready got=%b exp=1", in_ready);
        end
        send(16'h0F0F, 16'hF0F0);
        push_sample(16'h0F0F, 16'hF0F0);
        drain();
        wait_cnt(0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_pattern();
        test_back_to_back();
        test_wrap_accept();
        test_underrun_fill();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
